// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU-side bus of mem_responder: two read ports, one write port, hold and status.
interface mem_responder_if #(
  parameter int DATA_W = 16
);
  logic              ready;
  logic [14:0]       raddr0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  logic              rdata0_valid;
  logic [14:0]       raddr1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              rdata1_valid;
  logic              wen;
  logic [14:0]       waddr;
  logic [DATA_W-1:0] wdata;
  logic              hold;
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_fwd;

  modport master (
    output raddr0, rvalid0, raddr1, rvalid1, wen, waddr, wdata, hold,
    input  ready, rdata0, rdata0_valid, rdata1, rdata1_valid,
           stat_reads, stat_writes, stat_fwd
  );

  modport slave (
    input  raddr0, rvalid0, raddr1, rvalid1, wen, waddr, wdata, hold,
    output ready, rdata0, rdata0_valid, rdata1, rdata1_valid,
           stat_reads, stat_writes, stat_fwd
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Two-read/one-write memory responder with fixed latency, write forwarding and clear sweep.
// Optional statistics counters enabled by defining MEM_RESP_STATS_EN.
module mem_responder #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  run;
  logic                  adv;
  logic                  wr_ok;
  logic [DEPTH_LOG2-1:0] widx;
  logic [DEPTH_LOG2-1:0] ridx [2];
  logic [1:0]            rreq;
  logic [DATA_W-1:0]     cap_d [2];

  logic [LAT-1:0]        pv [2];
  logic [DEPTH_LOG2-1:0] pa [2][LAT];
  logic [DATA_W-1:0]     pd [2][LAT];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.raddr0[14:DEPTH_LOG2], bus.raddr1[14:DEPTH_LOG2],
                              bus.waddr[14:DEPTH_LOG2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && ptr == '1) state_nxt = ST_RUN;
  end

  always_comb begin
    run       = (state == ST_RUN);
    bus.ready = run;
  end

  // The sweep owns the write port while clearing, so stores are simply dropped then.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[ptr] <= '0;
    else if (bus.wen)      mem[widx] <= bus.wdata;
  end

  assign widx    = bus.waddr[DEPTH_LOG2-1:0];
  assign ridx[0] = bus.raddr0[DEPTH_LOG2-1:0];
  assign ridx[1] = bus.raddr1[DEPTH_LOG2-1:0];
  assign wr_ok   = run && bus.wen;
  assign adv     = !bus.hold;
  assign rreq    = {bus.rvalid1 && run && adv, bus.rvalid0 && run && adv};

  function automatic logic [DATA_W-1:0] fwd(input logic [DEPTH_LOG2-1:0] a,
                                            input logic [DATA_W-1:0]     d);
    return (wr_ok && a == widx) ? bus.wdata : d;
  endfunction

  always_comb begin
    for (int p = 0; p < 2; p++) cap_d[p] = fwd(ridx[p], mem[ridx[p]]);
  end

  // The last stage is the presented response; it is never rewritten once shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        pv[p] <= '0;
        for (int i = 0; i < LAT; i++) begin
          pa[p][i] <= '0;
          pd[p][i] <= '0;
        end
      end
    end else if (adv) begin
      for (int p = 0; p < 2; p++) begin
        pv[p][0] <= rreq[p];
        pa[p][0] <= ridx[p];
        pd[p][0] <= cap_d[p];
        for (int i = 1; i < LAT; i++) begin
          pv[p][i] <= pv[p][i-1];
          pa[p][i] <= pa[p][i-1];
          pd[p][i] <= fwd(pa[p][i-1], pd[p][i-1]);
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < LAT - 1; i++) pd[p][i] <= fwd(pa[p][i], pd[p][i]);
      end
    end
  end

  assign bus.rdata0       = pd[0][LAT-1];
  assign bus.rdata0_valid = pv[0][LAT-1];
  assign bus.rdata1       = pd[1][LAT-1];
  assign bus.rdata1_valid = pv[1][LAT-1];

`ifdef MEM_RESP_STATS_EN
  logic [31:0] n_reads, n_writes, n_fwd;
  logic        fwd_hit;
  logic [1:0]  rd_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + {31'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    rd_inc  = {1'b0, rreq[0]} + {1'b0, rreq[1]};
    fwd_hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < LAT - 1; i++) begin
        if (pv[p][i] && wr_ok && pa[p][i] == widx) fwd_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reads  <= '0;
      n_writes <= '0;
      n_fwd    <= '0;
    end else begin
      n_reads  <= sat_add(n_reads, rd_inc);
      n_writes <= sat_add(n_writes, {1'b0, wr_ok});
      n_fwd    <= sat_add(n_fwd, {1'b0, fwd_hit});
    end
  end

  assign bus.stat_reads  = n_reads;
  assign bus.stat_writes = n_writes;
  assign bus.stat_fwd    = n_fwd;
`else
  assign bus.stat_reads  = '0;
  assign bus.stat_writes = '0;
  assign bus.stat_fwd    = '0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - Scoreboard bench for mem_responder against a memory-snapshot reference model.
module tb_mem_responder;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 10;
  localparam int LAT        = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DATA_W)) bus();

  mem_responder #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int idx;
    int due;
  } rsp_t;

  rsp_t        scb [2][$];
  logic [15:0] mdl_mem [DEPTH];
  bit          mdl_run;
  int          sweep;
  int          adv;
  bit          last_adv;
  int          mdl_reads, mdl_writes, mdl_fwd;
  int          n_rsp [2];
  logic        prev_v [2];
  logic [15:0] prev_d [2];
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    scb[0].delete();
    scb[1].delete();
    mdl_run    = 1'b0;
    sweep      = 0;
    last_adv   = 1'b1;
    mdl_reads  = 0;
    mdl_writes = 0;
    mdl_fwd    = 0;
    prev_v[0]  = 1'b0;
    prev_v[1]  = 1'b0;
  endtask

  // A response carries the memory contents as of the edge on which it is presented.
  task automatic model_edge();
    int  wi;
    bit  hit;
    wi = int'(bus.waddr) % DEPTH;
    if (mdl_run && bus.wen) begin
      hit = 1'b0;
      for (int p = 0; p < 2; p++)
        foreach (scb[p][k]) if (scb[p][k].due > adv && scb[p][k].idx == wi) hit = 1'b1;
      if (hit) mdl_fwd++;
      mdl_writes++;
    end
    last_adv = !bus.hold;
    if (!bus.hold) adv++;
    if (mdl_run && !bus.hold) begin
      if (bus.rvalid0) begin
        scb[0].push_back('{idx: int'(bus.raddr0) % DEPTH, due: adv + LAT - 1});
        mdl_reads++;
      end
      if (bus.rvalid1) begin
        scb[1].push_back('{idx: int'(bus.raddr1) % DEPTH, due: adv + LAT - 1});
        mdl_reads++;
      end
    end
    if (mdl_run && bus.wen) mdl_mem[wi] = bus.wdata;
    if (!mdl_run) begin
      mdl_mem[sweep] = '0;
      sweep++;
      if (sweep == DEPTH) mdl_run = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rvalid0 = 1'b0;
    bus.rvalid1 = 1'b0;
    bus.wen     = 1'b0;
    bus.hold    = 1'b0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
    cycle();
    bus.wen = 1'b0;
  endtask

  task automatic rd0(input logic [14:0] a);
    bus.rvalid0 = 1'b1; bus.raddr0 = a;
    cycle();
    bus.rvalid0 = 1'b0;
  endtask

  function automatic logic [14:0] rand_addr();
    return {5'($urandom_range(0, 31)), 10'($urandom_range(0, 15))};
  endfunction

  task automatic check_stats(input string tag);
`ifdef MEM_RESP_STATS_EN
    check({tag, "_stat_reads"},  bus.stat_reads,  mdl_reads);
    check({tag, "_stat_writes"}, bus.stat_writes, mdl_writes);
    check({tag, "_stat_fwd"},    bus.stat_fwd,    mdl_fwd);
`else
    check({tag, "_stat_reads"},  bus.stat_reads,  0);
    check({tag, "_stat_writes"}, bus.stat_writes, 0);
    check({tag, "_stat_fwd"},    bus.stat_fwd,    0);
`endif
  endtask

  initial begin
    logic        v;
    logic [15:0] d;
    bit          exp_v;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        v = (p == 0) ? bus.rdata0_valid : bus.rdata1_valid;
        d = (p == 0) ? bus.rdata0 : bus.rdata1;
        if (rst) begin
          check($sformatf("rst_valid%0d", p), v, 0);
        end else if (last_adv) begin
          exp_v = scb[p].size() > 0 && scb[p][0].due == adv;
          check($sformatf("valid%0d", p), v, exp_v);
          if (exp_v) begin
            check($sformatf("data%0d_idx%0h", p, scb[p][0].idx), d, mdl_mem[scb[p][0].idx]);
            void'(scb[p].pop_front());
            n_rsp[p]++;
          end
        end else begin
          check($sformatf("hold_valid%0d", p), v, prev_v[p]);
          check($sformatf("hold_data%0d", p), d, prev_d[p]);
        end
        prev_v[p] = v;
        prev_d[p] = d;
      end
      if (!rst) check("ready", bus.ready, mdl_run);
    end
  end

  initial begin
    int          n0;
    logic [31:0] fwd0;
    idle();
    bus.raddr0 = '0; bus.raddr1 = '0; bus.waddr = '0; bus.wdata = '0;
    n_rsp[0] = 0; n_rsp[1] = 0;
    adv = 0;
    reset_model();

    repeat (3) cycle();
    check("rst_ready", bus.ready, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check_stats("rst");
    rst = 1'b0;

    repeat (DEPTH - 1) cycle();
    check("ready_early", bus.ready, 0);
    cycle();
    check("ready_rise", bus.ready, 1);

    rd0(15'h0123);
    repeat (LAT - 1) cycle();
    check("clear_valid", bus.rdata0_valid, 1);
    check("clear_data", bus.rdata0, 16'h0000);

    wr(15'h0010, 16'hBEEF);
    rd0(15'h0010);
    repeat (LAT - 1) cycle();
    check("raw_valid", bus.rdata0_valid, 1);
    check("raw_data", bus.rdata0, 16'hBEEF);

    wr(15'h0020, 16'h1111);
    fwd0 = bus.stat_fwd;
    bus.rvalid1 = 1'b1; bus.raddr1 = 15'h0020;
    cycle();
    bus.rvalid1 = 1'b0;
    repeat (LAT - 2) cycle();
    wr(15'h0020, 16'h2222);
    check("fwd_valid", bus.rdata1_valid, 1);
    check("fwd_data", bus.rdata1, 16'h2222);
    cycle();
`ifdef MEM_RESP_STATS_EN
    check("fwd_stat_delta", bus.stat_fwd - fwd0, 1);
`else
    check("fwd_stat_delta", bus.stat_fwd - fwd0, 0);
`endif

    for (int i = 1; i <= 4; i++) wr(15'(i), 16'hA000 + 16'(i));
    n0 = n_rsp[0];
    for (int i = 1; i <= 4; i++) rd0(15'(i));
    repeat (LAT + 1) cycle();
    check("b2b_count", n_rsp[0] - n0, 4);

    n0 = n_rsp[0];
    rd0(15'h0001);
    rd0(15'h0002);
    bus.hold = 1'b1; bus.rvalid0 = 1'b1; bus.raddr0 = 15'h0003;
    repeat (3) cycle();
    bus.hold = 1'b0; bus.rvalid0 = 1'b0;
    rd0(15'h0003);
    rd0(15'h0004);
    repeat (LAT + 1) cycle();
    check("hold_count", n_rsp[0] - n0, 4);

    wr(15'h0405, 16'hAAAA);
    bus.rvalid0 = 1'b1; bus.raddr0 = 15'h0005;
    bus.rvalid1 = 1'b1; bus.raddr1 = 15'h0005;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
    check("alias_data0", bus.rdata0, 16'hAAAA);
    check("alias_data1", bus.rdata1, 16'hAAAA);
    check("alias_equal", bus.rdata0, bus.rdata1);

    for (int k = 0; k < 400; k++) begin
      bus.hold    = ($urandom_range(0, 4) == 0);
      bus.rvalid0 = 1'($urandom_range(0, 1));
      bus.raddr0  = rand_addr();
      bus.rvalid1 = 1'($urandom_range(0, 1));
      bus.raddr1  = rand_addr();
      bus.wen     = ($urandom_range(0, 2) == 0);
      bus.waddr   = rand_addr();
      bus.wdata   = 16'($urandom);
      cycle();
    end
    idle();
    repeat (LAT + 1) cycle();
    check("drain0", scb[0].size(), 0);
    check("drain1", scb[1].size(), 0);
    check_stats("run");

    bus.rvalid0 = 1'b1; bus.raddr0 = 15'h0010;
    bus.rvalid1 = 1'b1; bus.raddr1 = 15'h0004;
    repeat (LAT) cycle();
    check("pre_rst_valid0", bus.rdata0_valid, 1);
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    check("async_valid0", bus.rdata0_valid, 0);
    check("async_valid1", bus.rdata1_valid, 0);
    check("async_ready", bus.ready, 0);
    check_stats("async");
    idle();
    cycle();
    rst = 1'b0;
    repeat (DEPTH - 1) cycle();
    check("resweep_early", bus.ready, 0);
    cycle();
    check("resweep_ready", bus.ready, 1);
    rd0(15'h0010);
    repeat (LAT - 1) cycle();
    check("resweep_valid", bus.rdata0_valid, 1);
    check("resweep_data", bus.rdata0, 16'h0000);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
